// File: rtl/apbm_pkg.sv
// Shared definitions for the APB initiator (apbm) and the rotator register
// slave: FSM state encoding, register address map, timeout helper.
package apbm_pkg;

    // Transfer sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RDWAIT = 3'd3,
        ST_RESP   = 3'd4
    } apbm_state_e;

    // Width of the ACCESS-phase wait counter
    localparam int unsigned TO_CNT_W = 16;

    // Rotator register address map
    localparam logic [31:0] DMA_SRC_IMG    = 32'h0000_0000;
    localparam logic [31:0] DMA_DST_IMG    = 32'h0000_0004;
    localparam logic [31:0] ROT_IMG_H      = 32'h0000_0008;
    localparam logic [31:0] ROT_IMG_W      = 32'h0000_000c;
    localparam logic [31:0] ROT_IMG_NEW_H  = 32'h0000_0010;
    localparam logic [31:0] ROT_IMG_NEW_W  = 32'h0000_0014;
    localparam logic [31:0] ROT_IMG_MODE   = 32'h0000_0018;
    localparam logic [31:0] ROT_IMG_DIR    = 32'h0000_001c;
    localparam logic [31:0] CTRL_START     = 32'h0000_0020;
    localparam logic [31:0] CTRL_RESET     = 32'h0000_0024;
    localparam logic [31:0] CTRL_INTR_MASK = 32'h0000_0028;

    // True in the last ACCESS cycle allowed before aborting; a zero limit
    // means the timeout is disabled and never fires.
    function automatic logic to_expired(input logic [TO_CNT_W-1:0] cnt,
                                        input logic [TO_CNT_W-1:0] limit);
        return (limit != 16'd0) && (cnt == (limit - 16'd1));
    endfunction

endpackage

// File: rtl/apbm_if.sv
// Command/response handshake and APB bus bundle for the apbm initiator.
// master: the apbm side; slave: the peer side (sequencer + register slave).
interface apbm_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_write;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wdata, cmd_write, rsp_ready, prdata, pready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               paddr, pwdata, pwrite, psel, penable
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wdata, cmd_write, rsp_ready, prdata, pready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               paddr, pwdata, pwrite, psel, penable
    );
endinterface

// File: rtl/apbm.sv
// APB initiator: runs each accepted register command as one APB transfer
// (SETUP then ACCESS) and returns read data or a timeout error.
module apbm
    import apbm_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int RD_LAT  = 1
) (
    input  logic   I_APBM_PCLK,
    input  logic   I_APBM_PRESET,
    apbm_if.master bus
);

    localparam logic [TO_CNT_W-1:0] TO_LIMIT  = TO_CNT_W'(TIMEOUT);
    localparam logic                RD_LAT_EN = (RD_LAT != 0);
    localparam logic [TO_CNT_W-1:0] TO_MAX    = {TO_CNT_W{1'b1}};

    apbm_state_e         state_r;
    logic [ADDR_W-1:0]   paddr_r;
    logic [DATA_W-1:0]   pwdata_r;
    logic                pwrite_r;
    logic                psel_r;
    logic                penable_r;
    logic                rsp_valid_r;
    logic [DATA_W-1:0]   rsp_rdata_r;
    logic                rsp_err_r;
    logic [TO_CNT_W-1:0] to_cnt_r;
    logic                cmd_ready_s;

    // Ready only in IDLE; forced low while reset is asserted
    always_comb begin
        cmd_ready_s = 1'b0;
        if ((state_r == ST_IDLE) && !I_APBM_PRESET) begin
            cmd_ready_s = 1'b1;
        end else begin
            cmd_ready_s = 1'b0;
        end
    end

    // Transfer sequencer with registered APB and response outputs
    always_ff @(posedge I_APBM_PCLK or posedge I_APBM_PRESET) begin
        if (I_APBM_PRESET) begin
            state_r     <= ST_IDLE;
            paddr_r     <= '0;
            pwdata_r    <= '0;
            pwrite_r    <= 1'b0;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
            to_cnt_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Address/data/direction stay at their last values until
                    // the next command is taken, so the bus never toggles idle.
                    if (bus.cmd_valid && cmd_ready_s) begin
                        paddr_r  <= bus.cmd_addr;
                        pwdata_r <= bus.cmd_wdata;
                        pwrite_r <= bus.cmd_write;
                        psel_r   <= 1'b1;
                        to_cnt_r <= '0;
                        state_r  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // PREADY is checked first so it wins over a same-cycle abort
                    if (bus.pready) begin
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                        if (pwrite_r) begin
                            rsp_rdata_r <= '0;
                            rsp_err_r   <= 1'b0;
                            rsp_valid_r <= 1'b1;
                            state_r     <= ST_RESP;
                        end else if (!RD_LAT_EN) begin
                            rsp_rdata_r <= bus.prdata;
                            rsp_err_r   <= 1'b0;
                            rsp_valid_r <= 1'b1;
                            state_r     <= ST_RESP;
                        end else begin
                            state_r <= ST_RDWAIT;
                        end
                    end else if (to_expired(to_cnt_r, TO_LIMIT)) begin
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        rsp_rdata_r <= '0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else if (to_cnt_r != TO_MAX) begin
                        // Saturate when the timeout is disabled
                        to_cnt_r <= to_cnt_r + 16'd1;
                    end else begin
                        to_cnt_r <= to_cnt_r;
                    end
                end
                ST_RDWAIT: begin
                    // Slave presents its registered read data this cycle
                    rsp_rdata_r <= bus.prdata;
                    rsp_err_r   <= 1'b0;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    psel_r      <= 1'b0;
                    penable_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.paddr     = paddr_r;
    assign bus.pwdata    = pwdata_r;
    assign bus.pwrite    = pwrite_r;
    assign bus.psel      = psel_r;
    assign bus.penable   = penable_r;

endmodule

// File: tb/tb_apbm.sv
// Testbench for apbm: two instances (registered-read slave and same-cycle
// read slave) driven with directed and random register commands, checked
// against a register-array model and latency/timeout arithmetic.
module tb_apbm;
    import apbm_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int          sel = 0;
    logic        drv_valid = 1'b0;
    logic        drv_write = 1'b0;
    logic        drv_rsp_ready = 1'b0;
    logic [31:0] drv_addr = 32'h0;
    logic [31:0] drv_wdata = 32'h0;
    int          slv_waits = 0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [2][16];
    logic [31:0] amap [11] = '{DMA_SRC_IMG, DMA_DST_IMG, ROT_IMG_H, ROT_IMG_W,
                               ROT_IMG_NEW_H, ROT_IMG_NEW_W, ROT_IMG_MODE,
                               ROT_IMG_DIR, CTRL_START, CTRL_RESET, CTRL_INTR_MASK};

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic init_ref();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                ref_mem[d][i] = init_val(i);
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 1 : 0;
        apbm_if #(.ADDR_W(32), .DATA_W(32)) bus ();

        apbm #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .RD_LAT(LAT)) u_dut (
            .I_APBM_PCLK   (clk),
            .I_APBM_PRESET (rst),
            .bus           (bus)
        );

        assign bus.cmd_valid = drv_valid && (sel == g);
        assign bus.cmd_addr  = drv_addr;
        assign bus.cmd_wdata = drv_wdata;
        assign bus.cmd_write = drv_write;
        assign bus.rsp_ready = drv_rsp_ready && (sel == g);

        // Register slave with programmable wait states
        logic [31:0] smem [16];
        int          acc_cnt;
        logic [31:0] rd_q;
        logic        rd_vld;
        logic [3:0]  sidx;
        assign sidx = bus.paddr[5:2];

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_cnt <= 0;
                rd_q    <= 32'h0;
                rd_vld  <= 1'b0;
                for (int i = 0; i < 16; i++) smem[i] <= init_val(i);
            end else if (bus.psel && bus.penable) begin
                if (bus.pready) begin
                    acc_cnt <= 0;
                    if (bus.pwrite) smem[sidx] <= bus.pwdata;
                    else            rd_q       <= smem[sidx];
                    rd_vld <= !bus.pwrite;
                end else begin
                    acc_cnt <= acc_cnt + 1;
                    rd_vld  <= 1'b0;
                end
            end else begin
                acc_cnt <= 0;
                rd_vld  <= 1'b0;
            end
        end

        assign bus.pready = bus.psel && bus.penable && (acc_cnt == slv_waits);
        assign bus.prdata = (LAT == 1) ? (rd_vld ? rd_q : 32'hBAD1_1BAD)
                                       : ((bus.pready && !bus.pwrite) ? smem[sidx] : 32'hBAD0_0BAD);
    end

    logic        m_cmd_ready, m_rsp_valid, m_rsp_err, m_pwrite, m_psel, m_penable;
    logic [31:0] m_rsp_rdata, m_paddr, m_pwdata;
    assign m_cmd_ready = (sel == 1) ? gen_dut[1].bus.cmd_ready : gen_dut[0].bus.cmd_ready;
    assign m_rsp_valid = (sel == 1) ? gen_dut[1].bus.rsp_valid : gen_dut[0].bus.rsp_valid;
    assign m_rsp_err   = (sel == 1) ? gen_dut[1].bus.rsp_err   : gen_dut[0].bus.rsp_err;
    assign m_rsp_rdata = (sel == 1) ? gen_dut[1].bus.rsp_rdata : gen_dut[0].bus.rsp_rdata;
    assign m_pwrite    = (sel == 1) ? gen_dut[1].bus.pwrite    : gen_dut[0].bus.pwrite;
    assign m_psel      = (sel == 1) ? gen_dut[1].bus.psel      : gen_dut[0].bus.psel;
    assign m_penable   = (sel == 1) ? gen_dut[1].bus.penable   : gen_dut[0].bus.penable;
    assign m_paddr     = (sel == 1) ? gen_dut[1].bus.paddr     : gen_dut[0].bus.paddr;
    assign m_pwdata    = (sel == 1) ? gen_dut[1].bus.pwdata    : gen_dut[0].bus.pwdata;

    // Wait (bounded) at negedges until the selected DUT offers cmd_ready
    task automatic wait_ready(input string tag);
        int t = 0;
        while (m_cmd_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq(tag, 32'(m_cmd_ready), 32'd1);
    endtask

    // One command: called and returning at a negedge
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input int hold);
        int          idx = int'(addr[5:2]);
        int          lat_exp, k, psel_n, pen_n;
        logic        err_exp, seen, bad_ready, bad_stable, bad_hold;
        logic [31:0] rd_exp;

        if (waits >= TO) begin
            err_exp = 1'b1;
            rd_exp  = 32'h0;
            lat_exp = 2 + TO;
        end else begin
            err_exp = 1'b0;
            lat_exp = 3 + waits + ((!wr && sel == 0) ? 1 : 0);
            if (wr) begin
                ref_mem[sel][idx] = wdata;
                rd_exp = 32'h0;
            end else begin
                rd_exp = ref_mem[sel][idx];
            end
        end

        slv_waits = waits;
        drv_write = wr;
        drv_addr  = addr;
        drv_wdata = wdata;
        drv_valid = 1'b1;
        wait_ready("cmd_ready_idle");
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;

        k = 1; seen = 1'b0; psel_n = 0; pen_n = 0;
        bad_ready = 1'b0; bad_stable = 1'b0;
        while (k <= 40 && !seen) begin
            if (m_rsp_valid) begin
                seen = 1'b1;
            end else begin
                if (m_cmd_ready) bad_ready = 1'b1;
                if (m_psel) psel_n++;
                if (m_penable) pen_n++;
                if (m_psel && (m_paddr !== addr || m_pwdata !== wdata || m_pwrite !== wr))
                    bad_stable = 1'b1;
                @(negedge clk);
                k++;
            end
        end
        check_eq("rsp_latency", 32'(k), 32'(lat_exp));
        check_eq("rsp_err", 32'(m_rsp_err), 32'(err_exp));
        check_eq("rsp_rdata", m_rsp_rdata, rd_exp);
        check_eq("psel_cycles", 32'(psel_n), (waits >= TO) ? 32'(1 + TO) : 32'(2 + waits));
        check_eq("penable_cycles", 32'(pen_n), (waits >= TO) ? 32'(TO) : 32'(1 + waits));
        check_eq("busy_not_ready", 32'(bad_ready), 32'd0);
        check_eq("pbus_stable", 32'(bad_stable), 32'd0);
        check_eq("psel_in_resp", 32'(m_psel), 32'd0);

        bad_hold = 1'b0;
        drv_valid = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!m_rsp_valid || m_rsp_rdata !== rd_exp || m_rsp_err !== err_exp ||
                m_cmd_ready || m_psel)
                bad_hold = 1'b1;
        end
        if (hold > 0) check_eq("rsp_hold_stable", 32'(bad_hold), 32'd0);

        drv_rsp_ready = 1'b1;
        @(negedge clk);
        drv_rsp_ready = 1'b0;
        drv_valid = 1'b0;
        check_eq("rsp_consumed", 32'(m_rsp_valid), 32'd0);
        check_eq("ready_after_rsp", 32'(m_cmd_ready), 32'd1);
    endtask

    // Reset pulse during ACCESS: bus drops at once, command is lost
    task automatic reset_mid();
        logic bad = 1'b0;
        slv_waits = 99;
        drv_write = 1'b1;
        drv_addr  = CTRL_RESET;
        drv_wdata = 32'h0000_0005;
        drv_valid = 1'b1;
        wait_ready("cmd_ready_pre_rst");
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        @(negedge clk);
        check_eq("access_before_rst", {30'h0, m_psel, m_penable}, 32'd3);
        #2 rst = 1'b1;
        #1;
        check_eq("psel_async_rst", 32'(m_psel), 32'd0);
        check_eq("penable_async_rst", 32'(m_penable), 32'd0);
        check_eq("ready_in_rst", 32'(m_cmd_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        init_ref();
        #1;
        check_eq("ready_after_rst", 32'(m_cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (m_rsp_valid || m_psel) bad = 1'b1;
        end
        check_eq("no_rsp_after_rst", 32'(bad), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        init_ref();
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", 32'(m_cmd_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", m_rsp_rdata, 32'h0);
        check_eq("rst_rsp_err", 32'(m_rsp_err), 32'd0);
        check_eq("rst_paddr", m_paddr, 32'h0);
        check_eq("rst_pwdata", m_pwdata, 32'h0);
        check_eq("rst_pctl", {29'h0, m_pwrite, m_psel, m_penable}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("ready_after_release", 32'(m_cmd_ready), 32'd1);
        @(negedge clk);

        // Registered-read slave
        sel = 0;
        do_cmd(1'b1, DMA_SRC_IMG, 32'h0000_1000, 0, 0);
        do_cmd(1'b0, DMA_SRC_IMG, 32'h0, 0, 0);
        do_cmd(1'b1, CTRL_START, 32'h0000_0001, 0, 0);
        do_cmd(1'b0, ROT_IMG_W, 32'h0, 99, 0);
        do_cmd(1'b1, ROT_IMG_MODE, 32'h0000_0003, TO - 1, 0);
        do_cmd(1'b1, ROT_IMG_DIR, 32'h0000_0002, TO, 5);
        do_cmd(1'b0, ROT_IMG_MODE, 32'h0, 2, 5);
        for (int n = 0; n < 20; n++)
            do_cmd(1'($urandom_range(0, 1)), amap[$urandom_range(0, 10)], $urandom,
                   int'($urandom_range(0, 9)), int'($urandom_range(0, 3)));
        reset_mid();
        do_cmd(1'b0, CTRL_RESET, 32'h0, 0, 0);
        do_cmd(1'b1, CTRL_RESET, 32'h0000_0007, 1, 0);

        // Same-cycle read slave
        sel = 1;
        do_cmd(1'b1, ROT_IMG_H, 32'hDEAD_BEEF, 0, 0);
        do_cmd(1'b0, ROT_IMG_H, 32'h0, 3, 0);
        do_cmd(1'b0, ROT_IMG_NEW_H, 32'h0, 0, 0);
        do_cmd(1'b0, CTRL_INTR_MASK, 32'h0, TO - 1, 2);
        do_cmd(1'b0, DMA_DST_IMG, 32'h0, TO + 3, 0);
        for (int n = 0; n < 15; n++)
            do_cmd(1'($urandom_range(0, 1)), amap[$urandom_range(0, 10)], $urandom,
                   int'($urandom_range(0, 9)), int'($urandom_range(0, 3)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
